ofifo_col_collect: RTL and testbench
====================================

# ofifo_col_collect

Output FIFO bank directly downstream of the 8x8 weight-stationary MAC array. It captures the per-column partial sums that leave the bottom row, each column qualified by its own valid bit and arriving skewed in time. It realigns them and presents complete rows of `col` psums to the accumulation/SFU stage through a first-word-fall-through read port.

## Interface
- `col`, 8, number of MAC columns, one FIFO lane each
- `psum_bw`, 16, width of one partial sum
- `depth`, 64, entries per lane; power of two, at least 2
- `clk`  input  1  single clock; all state updates on its rising edge
- `reset`  input  1  synchronous, active-low reset; sampled on rising `clk`; `reset`==0 clears all state
- `in`  input  psum_bw*col  psums from the array's `out_s`; lane c is bits [psum_bw*(c+1)-1 : psum_bw*c]
- `wr`  input  col  per-lane write strobe, driven by the array's `valid`
- `rd`  input  1  pop one row (one entry from every lane)
- `out`  output  psum_bw*col  head entry of every lane, same lane packing as `in`
- `o_valid`  output  1  every lane non-empty; `out` holds a complete row
- `full`  output  1  at least one lane holds `depth` entries
- `ready`  output  1  equals !`full`
- `overflow`  output  1  sticky; a write to a full lane was dropped

## Operation
- Each lane is a circular buffer with `depth` entries.
- Each lane has write and read pointers of log2(depth)+1 bits; the extra MSB distinguishes full from empty.
- Lane count = wptr - rptr, modulo 2^(log2(depth)+1).
- Lane empty when wptr==rptr.
- Lane full when the low bits of the two pointers are equal and the MSBs differ.
- Write, lane c: when `wr[c]`==1, the lane is accepted if it is not full, or if a pop occurs in the same cycle.
  - On acceptance, `in` lane c is stored at wptr[c] and wptr[c] increments, wrapping naturally.
  - Otherwise the data is dropped and `overflow` is set to 1.
- Lanes write independently; any subset of `wr` may be active in a cycle.
- Pop: occurs when `rd`==1 and `o_valid`==1. Every rptr increments by one in the same cycle.
- `rd` while `o_valid`==0 is ignored: no pointer moves and no flag changes.
- Simultaneous write and pop on a lane: both take effect and the lane count is unchanged.
  - An empty lane written in the pop cycle cannot occur, because a pop requires all lanes non-empty.
- `out` lane c = mem[c][rptr[c]], first-word-fall-through; it is valid whenever `o_valid`==1.
- `out` content is don't-care when `o_valid`==0; the bench must not check it then.
- `overflow` clears only on reset.
- Reset: all pointers go to 0. Outputs after reset: `o_valid`=0, `full`=0, `ready`=1, `overflow`=0.
  - Memory contents are not cleared.
  - Reset mid-stream discards all stored entries; `wr`/`rd` in the reset cycle are ignored.

## Timing
- Write-to-visible latency is 1 cycle: a write on edge N makes the entry countable after edge N.
- `o_valid` is registered-state derived, i.e. combinational from the pointers. It rises the cycle after the last lane receives its first entry.
- Pop on edge N: `out` shows the next row immediately after edge N if every lane still holds at least one entry. Otherwise `o_valid` falls after edge N.
- `full`/`ready` change the cycle after the write or pop that causes them.
- No combinational path from `rd` or `wr` to any output.
- Array skew: lane c's first valid arrives c cycles after lane 0's. `o_valid` rises one cycle after lane `col`-1 is written.
- Sustained throughput: one row per cycle once aligned. `rd` may be held high continuously.

## Structure
- The shared package holds:
  - `OFIFO_COL`, `OFIFO_PSUM_BW`, `OFIFO_DEPTH`
  - derived `OFIFO_PTR_BW` = log2(depth)+1
- One sub-module, `ofifo_lane`: a single-lane FWFT FIFO.
  - Ports: `clk`, `reset`, `wr`, `pop`, `in`, `out`, `empty`, `full`, `ovf`.
  - The top instantiates `col` lanes with a generate loop.
  - The top derives `o_valid` = AND of !empty, `full` = OR of full, and `overflow` = OR of ovf, registered sticky.
- The top alone computes the pop condition (`rd` & `o_valid`) and fans it to all lanes.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with `wr`=8'hFF, then release.
  - During and after reset: `o_valid`=0, `full`=0, `ready`=1, `overflow`=0.
- Skewed fill: assert `wr[c]` starting at cycle c with lane c data 16'h0100+c, then `rd` once.
  - `o_valid` rises one cycle after lane 7's write; `out` = {16'h0107,…,16'h0100}.
  - After the pop, `o_valid`=0.
- Streaming: skewed writes of 20 rows with `rd` held high.
  - 20 pops occur, in order, with no overflow. Lane values match row index k = 0..19.
- Full/wrap:
  - Write 64 entries to all lanes with no reads: `full`=1, `ready`=0.
  - A 65th write: `overflow`=1 and the data is dropped.
  - Pop 64 rows: data 0..63 in order, pointers wrap.
  - Then write and read 10 more rows: order preserved.
- Full with simultaneous write+pop: with all lanes full, assert `wr`=8'hFF and `rd`.
  - Write accepted, `overflow` unchanged, `full` stays 1; the next out row is the old second entry.
- Reset mid-operation: with 5 rows stored, pulse `reset`=0 for 1 cycle.
  - `o_valid`=0, and the previous entries never reappear.
  - `rd` with `o_valid`=0 causes no pointer change.

Source files
------------

// File: rtl/ofifo_col_collect_pkg.sv
// Shared sizing for the MAC-array output FIFO bank and its per-column lanes.
package ofifo_col_collect_pkg;

  localparam int unsigned OFIFO_COL     = 8;
  localparam int unsigned OFIFO_PSUM_BW = 16;
  localparam int unsigned OFIFO_DEPTH   = 64;
  localparam int unsigned OFIFO_ADDR_BW = $clog2(OFIFO_DEPTH);
  localparam int unsigned OFIFO_PTR_BW  = OFIFO_ADDR_BW + 1;
  localparam int unsigned OFIFO_ROW_BW  = OFIFO_PSUM_BW * OFIFO_COL;

  typedef logic [OFIFO_PSUM_BW-1:0] psum_t;

endpackage

// File: rtl/ofifo_lane.sv
// Single-lane first-word-fall-through FIFO. The pointers carry an extra MSB that separates full from empty.
module ofifo_lane
  import ofifo_col_collect_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  wr,
  input  logic  pop,
  input  psum_t in,
  output psum_t out,
  output logic  empty,
  output logic  full,
  output logic  ovf
);

  logic [OFIFO_PTR_BW-1:0] r_wptr;
  logic [OFIFO_PTR_BW-1:0] r_rptr;
  psum_t                   r_mem [OFIFO_DEPTH];
  logic                    w_accept;

  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[OFIFO_ADDR_BW-1:0] == r_rptr[OFIFO_ADDR_BW-1:0]) &&
                 (r_wptr[OFIFO_ADDR_BW] != r_rptr[OFIFO_ADDR_BW]);

  // A full lane still takes a write when the head leaves in the same cycle.
  assign w_accept = reset && wr && (!full || pop);
  assign ovf      = reset && wr && full && !pop;

  assign out = r_mem[r_rptr[OFIFO_ADDR_BW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_accept) r_wptr <= r_wptr + OFIFO_PTR_BW'(1);
      if (pop)      r_rptr <= r_rptr + OFIFO_PTR_BW'(1);
    end
  end

  // Storage is intentionally not reset; stale entries are hidden by the pointers.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wptr[OFIFO_ADDR_BW-1:0]] <= in;
  end

endmodule

// File: rtl/ofifo_col_collect.sv
// Realigns skewed per-column psums from the MAC array into complete rows behind an FWFT read port.
module ofifo_col_collect
  import ofifo_col_collect_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [OFIFO_ROW_BW-1:0] in,
  input  logic [OFIFO_COL-1:0]    wr,
  input  logic                    rd,
  output logic [OFIFO_ROW_BW-1:0] out,
  output logic                    o_valid,
  output logic                    full,
  output logic                    ready,
  output logic                    overflow
);

  logic [OFIFO_COL-1:0] w_empty;
  logic [OFIFO_COL-1:0] w_full;
  logic [OFIFO_COL-1:0] w_ovf;
  logic                 w_pop;
  logic                 r_overflow;

  // One row leaves only when every lane has its entry, so all lanes pop together.
  assign w_pop = rd && o_valid;

  for (genvar c = 0; c < OFIFO_COL; c++) begin : g_lane
    ofifo_lane u_lane (
      .clk   (clk),
      .reset (reset),
      .wr    (wr[c]),
      .pop   (w_pop),
      .in    (in[OFIFO_PSUM_BW*c +: OFIFO_PSUM_BW]),
      .out   (out[OFIFO_PSUM_BW*c +: OFIFO_PSUM_BW]),
      .empty (w_empty[c]),
      .full  (w_full[c]),
      .ovf   (w_ovf[c])
    );
  end

  assign o_valid  = ~|w_empty;
  assign full     = |w_full;
  assign ready    = ~full;
  assign overflow = r_overflow;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (|w_ovf) begin
      r_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ofifo_col_collect.sv
// Self-checking bench for ofifo_col_collect: directed table, corner sequences and a queue-based random reference.
module tb_ofifo_col_collect;

  logic         clk;
  logic         rst_l;
  logic [127:0] tb_in;
  logic [7:0]   tb_wr;
  logic         tb_rd;
  logic [127:0] tb_out;
  logic         o_valid;
  logic         full;
  logic         ready;
  logic         overflow;

  ofifo_col_collect dut (
    .clk      (clk),
    .reset    (rst_l),
    .in       (tb_in),
    .wr       (tb_wr),
    .rd       (tb_rd),
    .out      (tb_out),
    .o_valid  (o_valid),
    .full     (full),
    .ready    (ready),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  // Reference: one queue per lane plus the sticky overflow bit.
  logic [15:0] mq [8][$];
  logic        m_ovf;

  typedef struct {
    logic         rst;
    logic [7:0]   w;
    logic [127:0] d;
    logic         r;
    logic         ev;
    logic         ef;
    logic         eovf;
    logic [127:0] eout;
  } vec_t;

  vec_t tbl[12];

  task automatic cmp(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [127:0] row_vec(input int k);
    logic [127:0] v;
    v = '0;
    for (int c = 0; c < 8; c++) v[16*c +: 16] = {8'(c), 8'(k)};
    return v;
  endfunction

  function automatic logic all_nonempty();
    logic a;
    a = 1'b1;
    for (int c = 0; c < 8; c++) if (mq[c].size() == 0) a = 1'b0;
    return a;
  endfunction

  // Drive one cycle of inputs, advance past the edge, then apply the same cycle to the reference.
  task automatic step(input logic rst, input logic [7:0] w, input logic [127:0] d, input logic r);
    logic pop;
    rst_l = rst; tb_wr = w; tb_in = d; tb_rd = r;
    pop = rst && r && all_nonempty();
    @(posedge clk);
    #1;
    if (!rst) begin
      for (int c = 0; c < 8; c++) mq[c].delete();
      m_ovf = 1'b0;
    end else begin
      for (int c = 0; c < 8; c++) begin
        if (w[c]) begin
          if (mq[c].size() < 64 || pop) mq[c].push_back(d[16*c +: 16]);
          else m_ovf = 1'b1;
        end
      end
      if (pop) for (int c = 0; c < 8; c++) void'(mq[c].pop_front());
    end
  endtask

  task automatic check_model(input string tag);
    logic [127:0] eo;
    logic ev, ef;
    ev = 1'b1; ef = 1'b0; eo = '0;
    for (int c = 0; c < 8; c++) begin
      if (mq[c].size() == 0) ev = 1'b0;
      if (mq[c].size() == 64) ef = 1'b1;
      if (mq[c].size() > 0) eo[16*c +: 16] = mq[c][0];
    end
    cmp({tag, ".o_valid"}, 128'(o_valid), 128'(ev));
    cmp({tag, ".full"}, 128'(full), 128'(ef));
    cmp({tag, ".ready"}, 128'(ready), 128'(!ef));
    cmp({tag, ".overflow"}, 128'(overflow), 128'(m_ovf));
    if (ev) cmp({tag, ".out"}, tb_out, eo);
  endtask

  initial begin
    logic [127:0] sk;
    int sidx;
    logic [7:0] w;
    logic [127:0] d;
    logic r;
    n_cmp = 0; n_fail = 0; m_ovf = 1'b0;
    rst_l = 1'b0; tb_wr = '0; tb_in = '0; tb_rd = 1'b0;

    sk = '0;
    for (int c = 0; c < 8; c++) sk[16*c +: 16] = 16'h0100 + 16'(c);

    // Reset with writes asserted, rd on empty, skewed single-row fill, single pop.
    tbl[0] = '{1'b0, 8'hFF, sk, 1'b0, 1'b0, 1'b0, 1'b0, '0};
    tbl[1] = '{1'b0, 8'hFF, sk, 1'b0, 1'b0, 1'b0, 1'b0, '0};
    tbl[2] = '{1'b1, 8'h00, sk, 1'b1, 1'b0, 1'b0, 1'b0, '0};
    for (int i = 0; i < 8; i++)
      tbl[3+i] = '{1'b1, 8'(1 << i), sk, 1'b0, (i == 7), 1'b0, 1'b0, sk};
    tbl[11] = '{1'b1, 8'h00, sk, 1'b1, 1'b0, 1'b0, 1'b0, '0};

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rst, tbl[i].w, tbl[i].d, tbl[i].r);
      cmp($sformatf("tbl%0d.o_valid", i), 128'(o_valid), 128'(tbl[i].ev));
      cmp($sformatf("tbl%0d.full", i), 128'(full), 128'(tbl[i].ef));
      cmp($sformatf("tbl%0d.ready", i), 128'(ready), 128'(!tbl[i].ef));
      cmp($sformatf("tbl%0d.overflow", i), 128'(overflow), 128'(tbl[i].eovf));
      if (tbl[i].ev) cmp($sformatf("tbl%0d.out", i), tb_out, tbl[i].eout);
    end

    // Skewed streaming of 20 rows with rd held high.
    sidx = 0;
    for (int t = 0; t < 30; t++) begin
      if (o_valid) begin
        cmp($sformatf("stream.row%0d", sidx), tb_out, row_vec(sidx));
        sidx++;
      end
      w = '0; d = '0;
      for (int c = 0; c < 8; c++) begin
        if (t >= c && t - c < 20) begin
          w[c] = 1'b1;
          d[16*c +: 16] = {8'(c), 8'(t - c)};
        end
      end
      step(1'b1, w, d, 1'b1);
      check_model("stream");
    end
    cmp("stream.pops", 128'(sidx), 128'(20));
    cmp("stream.overflow", 128'(overflow), 128'(0));

    // Fill to full, drop a 65th write, drain with wrap, then ten more rows.
    step(1'b0, 8'h00, '0, 1'b0);
    for (int k = 0; k < 64; k++) step(1'b1, 8'hFF, row_vec(k), 1'b0);
    cmp("wrap.full", 128'(full), 128'(1));
    cmp("wrap.ready", 128'(ready), 128'(0));
    cmp("wrap.ovf_before", 128'(overflow), 128'(0));
    step(1'b1, 8'hFF, row_vec(99), 1'b0);
    cmp("wrap.ovf_after", 128'(overflow), 128'(1));
    for (int k = 0; k < 64; k++) begin
      cmp($sformatf("wrap.valid%0d", k), 128'(o_valid), 128'(1));
      cmp($sformatf("wrap.row%0d", k), tb_out, row_vec(k));
      step(1'b1, 8'h00, '0, 1'b1);
    end
    cmp("wrap.drained", 128'(o_valid), 128'(0));
    for (int k = 0; k < 12; k++) begin
      step(1'b1, (k < 10) ? 8'hFF : 8'h00, row_vec(200 + k), 1'b1);
      check_model("wrap.post");
    end

    // Full bank with simultaneous write and pop.
    step(1'b0, 8'h00, '0, 1'b0);
    for (int k = 0; k < 64; k++) step(1'b1, 8'hFF, row_vec(k), 1'b0);
    step(1'b1, 8'hFF, row_vec(150), 1'b1);
    cmp("fullrw.full", 128'(full), 128'(1));
    cmp("fullrw.overflow", 128'(overflow), 128'(0));
    cmp("fullrw.out", tb_out, row_vec(1));
    check_model("fullrw");

    // Reset mid-stream discards stored rows.
    step(1'b0, 8'h00, '0, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b1, 8'hFF, row_vec(40 + k), 1'b0);
    step(1'b0, 8'hFF, row_vec(77), 1'b1);
    cmp("midrst.o_valid", 128'(o_valid), 128'(0));
    cmp("midrst.full", 128'(full), 128'(0));
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 8'h00, '0, 1'b1);
      cmp("midrst.idle_valid", 128'(o_valid), 128'(0));
    end
    step(1'b1, 8'hFF, row_vec(88), 1'b0);
    cmp("midrst.new_valid", 128'(o_valid), 128'(1));
    cmp("midrst.new_out", tb_out, row_vec(88));
    check_model("midrst");

    // Random traffic in phases biased toward filling or draining.
    for (int t = 0; t < 3000; t++) begin
      logic rst;
      int rd_pct;
      rd_pct = ((t / 250) % 2 == 0) ? 15 : 85;
      rst = ($urandom_range(0, 399) != 0);
      for (int c = 0; c < 8; c++) w[c] = ($urandom_range(0, 99) < 70);
      d = {$urandom, $urandom, $urandom, $urandom};
      r = ($urandom_range(0, 99) < rd_pct);
      step(rst, w, d, r);
      check_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
